// File: rtl/i2c_pkg.sv
// ----------------------------------------------------------------------------
// i2c_pkg
// Definitions shared by the I2C target (i2c_slave) and the I2C controller
// (i2c_master).
//   I2C_DEF_ADDR    : default 7-bit target address
//   i2c_slv_state_t : protocol state of the target
// ----------------------------------------------------------------------------
package i2c_pkg;

    localparam logic [6:0] I2C_DEF_ADDR = 7'b001_0000;

    typedef enum logic [2:0] {
        IDLE,       // bus not addressed to us; waiting for START
        ADDR,       // shifting in 7 address bits + R/W
        ADDR_ACK,   // driving the address ACK
        WR_DATA,    // receiving a byte from the master
        WR_ACK,     // driving the ACK for a received byte
        RD_DATA,    // shifting a byte out to the master
        RD_ACK,     // sampling the master ACK/NACK
        WAIT_STOP   // not ours (or NACKed): hands off until STOP/START
    } i2c_slv_state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// ----------------------------------------------------------------------------
// i2c_line_sync
// Brings SCL/SDA into the clk domain (2 flops each, preset to 1 = idle bus)
// and derives single-cycle event strobes from the synchronized values.
//   clk, rst   : system clock, async active-low reset
//   scl_i      : raw SCL
//   sda_i      : raw SDA (bus value, including our own drive)
//   sda_s      : synchronized SDA level
//   scl_rise   : 1-clk strobe on synchronized SCL 0->1
//   scl_fall   : 1-clk strobe on synchronized SCL 1->0
//   start_det  : SDA fell while SCL was high
//   stop_det   : SDA rose while SCL was high
// ----------------------------------------------------------------------------
module i2c_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [1:0] scl_sync_q;
    logic [1:0] sda_sync_q;
    logic       scl_prev_q;
    logic       sda_prev_q;
    logic       scl_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
            scl_prev_q <= scl_sync_q[1];
            sda_prev_q <= sda_sync_q[1];
        end
    end

    assign scl_s    = scl_sync_q[1];
    assign sda_s    = sda_sync_q[1];
    assign scl_rise =  scl_s & ~scl_prev_q;
    assign scl_fall = ~scl_s &  scl_prev_q;

    // SCL must be high both before and after the SDA change, so an SDA edge
    // that lands in the same clk as an SCL edge is never taken for START/STOP.
    assign start_det = scl_s & scl_prev_q &  sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q &  sda_s;

endmodule

// File: rtl/i2c_slave.sv
// ----------------------------------------------------------------------------
// i2c_slave
// 7-bit-address I2C target, no clock stretching. Received bytes are presented
// on data_out with a one-clk o_rxff_wr strobe; bytes to send are taken from
// data_in with a one-clk o_txff_rd strobe. clk must be >= 8x the SCL rate.
//   SLAVE_ADDR : address this target answers to
//   clk, rst   : system clock, async active-low reset
//   scl        : I2C clock (input only)
//   sda        : I2C data, open drain (driven 0 or released)
//   data_in    : next byte to transmit, consumed on o_txff_rd
//   o_txff_rd  : data_in consumed
//   data_out   : last byte received
//   o_rxff_wr  : data_out holds a new byte
//   busy       : addressed; from address match until STOP
// ----------------------------------------------------------------------------
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = I2C_DEF_ADDR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] data_in,
    output logic       o_txff_rd,
    output logic [7:0] data_out,
    output logic       o_rxff_wr,
    output logic       busy
);

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_line_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl),
        .sda_i     (sda),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    i2c_slv_state_t state_q, state_d;
    logic [3:0]     bcnt_q, bcnt_d;     // bits of the current byte, wraps 8->0
    logic [7:0]     shreg_q, shreg_d;
    logic           oe_q, oe_d;         // 1 = pull sda low
    logic [7:0]     dout_q, dout_d;
    logic           rxwr_q, rxwr_d;
    logic           txrd_q, txrd_d;
    logic           busy_q, busy_d;
    logic           rw_q, rw_d;
    logic           mack_q, mack_d;     // master ACKed the byte just sent
    logic           load_rd;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            bcnt_q  <= 4'd0;
            shreg_q <= 8'h00;
            oe_q    <= 1'b0;
            dout_q  <= 8'h00;
            rxwr_q  <= 1'b0;
            txrd_q  <= 1'b0;
            busy_q  <= 1'b0;
            rw_q    <= 1'b0;
            mack_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            shreg_q <= shreg_d;
            oe_q    <= oe_d;
            dout_q  <= dout_d;
            rxwr_q  <= rxwr_d;
            txrd_q  <= txrd_d;
            busy_q  <= busy_d;
            rw_q    <= rw_d;
            mack_q  <= mack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        shreg_d = shreg_q;
        oe_d    = oe_q;
        dout_d  = dout_q;
        rxwr_d  = 1'b0;
        txrd_d  = 1'b0;
        busy_d  = busy_q;
        rw_d    = rw_q;
        mack_d  = mack_q;
        load_rd = 1'b0;

        // Bus conditions win over any SCL edge seen in the same clk.
        if (stop_det) begin
            state_d = IDLE;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
            bcnt_d  = 4'd0;
        end else if (start_det) begin
            // Repeated START keeps busy: the transaction is still ours.
            state_d = ADDR;
            oe_d    = 1'b0;
            bcnt_d  = 4'd0;
            shreg_d = 8'h00;
        end else begin
            case (state_q)
                ADDR: begin
                    if (scl_rise) begin
                        shreg_d = {shreg_q[6:0], sda_s};
                        bcnt_d  = bcnt_q + 4'd1;
                    end else if (scl_fall && bcnt_q == 4'd8) begin
                        bcnt_d = 4'd0;
                        if (shreg_q[7:1] == SLAVE_ADDR) begin
                            oe_d    = 1'b1;
                            busy_d  = 1'b1;
                            rw_d    = shreg_q[0];
                            state_d = ADDR_ACK;
                        end else begin
                            state_d = WAIT_STOP;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (rw_q) begin
                            load_rd = 1'b1;
                        end else begin
                            oe_d    = 1'b0;
                            state_d = WR_DATA;
                        end
                    end
                end
                WR_DATA: begin
                    if (scl_rise) begin
                        shreg_d = {shreg_q[6:0], sda_s};
                        bcnt_d  = bcnt_q + 4'd1;
                        if (bcnt_q == 4'd7) begin
                            dout_d = {shreg_q[6:0], sda_s};
                            rxwr_d = 1'b1;
                        end
                    end else if (scl_fall && bcnt_q == 4'd8) begin
                        oe_d    = 1'b1;
                        bcnt_d  = 4'd0;
                        state_d = WR_ACK;
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        oe_d    = 1'b0;
                        state_d = WR_DATA;
                    end
                end
                RD_DATA: begin
                    // Count on rises, change the drive on falls; the fall
                    // after the 8th rise hands sda to the master.
                    if (scl_rise) begin
                        bcnt_d = bcnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bcnt_q == 4'd8) begin
                            oe_d    = 1'b0;
                            bcnt_d  = 4'd0;
                            mack_d  = 1'b0;
                            state_d = RD_ACK;
                        end else begin
                            oe_d    = ~shreg_q[6];
                            shreg_d = {shreg_q[6:0], 1'b0};
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s) mack_d  = 1'b1;
                        else        state_d = WAIT_STOP;
                    end else if (scl_fall && mack_q) begin
                        load_rd = 1'b1;
                    end
                end
                default: ;  // IDLE, WAIT_STOP: only START/STOP matter
            endcase
        end

        // Entering RD_DATA: take the next byte and put its MSB on the bus.
        if (load_rd) begin
            shreg_d = data_in;
            txrd_d  = 1'b1;
            oe_d    = ~data_in[7];
            bcnt_d  = 4'd0;
            state_d = RD_DATA;
        end
    end

    assign sda       = oe_q ? 1'b0 : 1'bz;
    assign data_out  = dout_q;
    assign o_rxff_wr = rxwr_q;
    assign o_txff_rd = txrd_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
`timescale 1ns/1ps
module tb_i2c_slave;

    localparam int         Q    = 4;       // clks per quarter SCL period
    localparam logic [6:0] ADDR = 7'h10;

    logic       clk     = 1'b0;
    logic       rst     = 1'b0;
    logic       scl     = 1'b1;
    logic       sda_drv = 1'b0;            // master pulls sda low
    logic [7:0] data_in = 8'hFF;
    logic [7:0] data_out;
    logic       o_txff_rd, o_rxff_wr, busy;
    wire        sda;

    assign sda = sda_drv ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_slave #(.SLAVE_ADDR(ADDR)) dut (
        .clk       (clk),
        .rst       (rst),
        .scl       (scl),
        .sda       (sda),
        .data_in   (data_in),
        .o_txff_rd (o_txff_rd),
        .data_out  (data_out),
        .o_rxff_wr (o_rxff_wr),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- monitors / reference model state ----------------
    logic [7:0] rx_got[$];   // bytes reported by the DUT
    logic [7:0] exp_rx[$];   // bytes the model says should have been reported
    logic [7:0] tx_arr[$];   // bytes offered to the DUT for reading, in order
    int         tx_idx  = 0; // o_txff_rd pulses seen
    int         exp_tx  = 0;
    int         low_cnt = 0; // clks where sda was low with master released
    int         rx_chk  = 0;
    logic [7:0] wbuf[8];

    always @(negedge clk) begin
        if (o_rxff_wr) rx_got.push_back(data_out);
        if (o_txff_rd) tx_idx++;
        if (!sda_drv && sda === 1'b0) low_cnt++;
        data_in = (tx_idx < tx_arr.size()) ? tx_arr[tx_idx] : 8'hFF;
    end

    task automatic sync_rx();
        chk("rx_cnt", rx_got.size(), exp_rx.size());
        for (int i = rx_chk; i < rx_got.size() && i < exp_rx.size(); i++)
            chk("rx_data", rx_got[i], exp_rx[i]);
        rx_chk = rx_got.size();
    endtask

    // ---------------- bus master ----------------
    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic m_start();
        if (!scl) begin
            sda_drv = 1'b0; wclk(Q);
            scl = 1'b1;     wclk(Q);
        end
        sda_drv = 1'b1; wclk(Q);
        scl = 1'b0;     wclk(Q);
    endtask

    task automatic m_stop();
        sda_drv = 1'b1; wclk(Q);
        scl = 1'b1;     wclk(Q);
        sda_drv = 1'b0; wclk(2*Q);
    endtask

    task automatic m_bit_w(input logic b);
        sda_drv = !b; wclk(Q);
        scl = 1'b1;   wclk(2*Q);
        scl = 1'b0;   wclk(Q);
    endtask

    task automatic m_bit_r(output logic b);
        sda_drv = 1'b0; wclk(Q);
        scl = 1'b1;     wclk(Q);
        b = sda;        wclk(Q);
        scl = 1'b0;     wclk(Q);
    endtask

    task automatic m_wbyte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) m_bit_w(d[i]);
        m_bit_r(b);
        ack = !b;
    endtask

    task automatic m_rbyte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin m_bit_r(b); d[i] = b; end
        m_bit_w(!ack);
    endtask

    // One complete transaction; expectations follow the protocol rules:
    // ACK iff the address matches, written bytes reported in order, read
    // bytes are the offered bytes in order, one consumption per byte read.
    task automatic txn(input logic [6:0] a, input logic rd, input int n);
        logic       ack;
        logic [7:0] d;
        logic       hit = (a == ADDR);
        int         l0  = low_cnt;
        if (rd && hit)
            for (int i = 0; i < n; i++) begin tx_arr.push_back(wbuf[i]); exp_tx++; end
        m_start();
        m_wbyte({a, rd}, ack);
        chk("addr_ack", ack, hit);
        chk("busy_addr", busy, hit);
        for (int i = 0; i < n; i++) begin
            if (!rd) begin
                m_wbyte(wbuf[i], ack);
                chk("wr_ack", ack, hit);
                if (hit) exp_rx.push_back(wbuf[i]);
            end else begin
                m_rbyte(d, i < n - 1);
                chk("rd_data", d, hit ? wbuf[i] : 8'hFF);
            end
        end
        if (rd) begin wclk(Q); chk("rel_nack", sda, 1'b1); end
        if (!hit) chk("no_drive", low_cnt - l0, 0);
        m_stop();
        chk("busy_stop", busy, 1'b0);
        sync_rx();
        chk("txrd_cnt", tx_idx, exp_tx);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic       ack;
        logic [7:0] d;
        logic [7:0] ab;
        int         l0;

        wclk(3);
        chk("rst_sda", sda, 1'b1);
        chk("rst_dout", data_out, 8'h00);
        chk("rst_rxwr", o_rxff_wr, 1'b0);
        chk("rst_txrd", o_txff_rd, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b1;
        wclk(4*Q);

        // write 0x10+W: 00 08 04 02
        wbuf[0] = 8'h00; wbuf[1] = 8'h08; wbuf[2] = 8'h04; wbuf[3] = 8'h02;
        txn(ADDR, 1'b0, 4);

        // wrong address
        wbuf[0] = 8'h5A;
        txn(7'h11, 1'b0, 1);

        // read A5 (ACK) then 3C (NACK)
        wbuf[0] = 8'hA5; wbuf[1] = 8'h3C;
        txn(ADDR, 1'b1, 2);

        // write 55, repeated START, read one byte with NACK
        tx_arr.push_back(8'hC3); exp_tx++;
        m_start();
        m_wbyte({ADDR, 1'b0}, ack); chk("rs_addr_w", ack, 1'b1);
        m_wbyte(8'h55, ack);        chk("rs_wr_ack", ack, 1'b1);
        exp_rx.push_back(8'h55);
        chk("rs_busy1", busy, 1'b1);
        m_start();
        chk("rs_busy2", busy, 1'b1);
        m_wbyte({ADDR, 1'b1}, ack); chk("rs_addr_r", ack, 1'b1);
        m_rbyte(d, 1'b0);           chk("rs_rd", d, 8'hC3);
        chk("rs_busy3", busy, 1'b1);
        m_stop();
        chk("rs_busy_stop", busy, 1'b0);
        sync_rx();
        chk("rs_txrd", tx_idx, exp_tx);

        // STOP after 4 bits of a data byte
        m_start();
        m_wbyte({ADDR, 1'b0}, ack); chk("part_addr", ack, 1'b1);
        for (int i = 0; i < 4; i++) m_bit_w(i[0]);
        m_stop();
        chk("part_busy", busy, 1'b0);
        sync_rx();

        // reset while the slave drives the address ACK
        ab = {ADDR, 1'b0};
        m_start();
        for (int i = 7; i >= 0; i--) m_bit_w(ab[i]);
        sda_drv = 1'b0; wclk(Q);
        chk("ack_drv", sda, 1'b0);
        rst = 1'b0;
        #1;
        chk("rst_rel", sda, 1'b1);
        chk("rst2_dout", data_out, 8'h00);
        chk("rst2_rxwr", o_rxff_wr, 1'b0);
        chk("rst2_txrd", o_txff_rd, 1'b0);
        chk("rst2_busy", busy, 1'b0);
        wclk(2);
        rst = 1'b1;
        scl = 1'b1; wclk(2*Q);
        scl = 1'b0; wclk(Q);
        // no START since reset: a full byte must be ignored
        l0 = low_cnt;
        m_wbyte({ADDR, 1'b0}, ack);
        chk("post_rst_ack", ack, 1'b0);
        chk("post_rst_drv", low_cnt - l0, 0);
        m_stop();
        chk("post_rst_busy", busy, 1'b0);
        rx_chk = rx_got.size();   // entries before reset already checked
        sync_rx();

        // randomized transactions
        for (int t = 0; t < 10; t++) begin
            logic [6:0] a;
            logic       rd;
            int         n;
            rd = 1'($urandom_range(0, 1));
            n  = $urandom_range(1, 4);
            if ($urandom_range(0, 3) != 0) a = ADDR;
            else begin
                a = 7'($urandom);
                if (a == ADDR) a = a ^ 7'h01;
            end
            for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
            txn(a, rd, n);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'b001_0000, the 7-bit address this target answers to.
REQ-002 SHALL have port clk  input  1  system clock; one clock domain, rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port scl  input  1  I2C clock from the master; no clock stretching.
REQ-005 SHALL have port sda  inout  1  I2C data, open-drain: driven 0 or high-Z, never driven 1.
REQ-006 SHALL have port data_in  input  8  next byte to transmit, read when o_txff_rd pulses.
REQ-007 SHALL have port o_txff_rd  output  1  one-cycle pulse: data_in consumed.
REQ-008 SHALL have port data_out  output  8  last byte received from the master.
REQ-009 SHALL have port o_rxff_wr  output  1  one-cycle pulse: data_out holds a new byte.
REQ-010 SHALL have port busy  output  1  high from an address match until STOP.

Function
REQ-011 SHALL synchronize scl and sda through 2 flops each, then detect edges on the synchronized values; clk SHALL be at least 8x the SCL rate.
REQ-012 SHALL detect START as sda falling while scl high, and STOP as sda rising while scl high.
REQ-013 SHALL sample sda on each synchronized scl rising edge, MSB first.
REQ-014 SHALL change its sda drive only on synchronized scl falling edges.
REQ-015 SHALL implement states IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK and WAIT_STOP.
REQ-016 SHALL go from IDLE to ADDR on START and shift in 8 bits: 7 address bits, then R/W.
REQ-017 SHALL, on address == SLAVE_ADDR, drive sda low from the 8th scl fall to the 9th scl fall (ACK) and set busy.
REQ-018 SHALL, after the ACK, enter WR_DATA if R/W=0 or RD_DATA if R/W=1.
REQ-019 SHALL, on address mismatch, leave sda released, keep busy low and enter WAIT_STOP.
REQ-020 SHALL, in WR_DATA, set data_out and pulse o_rxff_wr for 1 clk, exactly 1 clk after the scl rise of the 8th bit.
REQ-021 SHALL, in WR_DATA, then ACK (WR_ACK) and return to WR_DATA; every written byte is ACKed.
REQ-022 SHALL, on each RD_DATA entry (the scl fall ending an ACK slot), load data_in, pulse o_txff_rd for 1 clk and drive the MSB in the same cycle.
REQ-023 SHALL, in RD_DATA, release sda after the 8th bit's scl fall and sample the master ACK/NACK at the 9th scl rise (RD_ACK).
REQ-024 SHALL, in RD_ACK, go to RD_DATA on ACK=0 and to WAIT_STOP with sda released on NACK=1.
REQ-025 SHALL treat a repeated START in any state as a new transaction: release sda, clear the bit count, enter ADDR.
REQ-026 SHALL treat STOP in any state as the end of the transaction: release sda, clear busy, enter IDLE; a partial byte is discarded and no o_rxff_wr is issued.
REQ-027 SHALL use a 4-bit bit counter that wraps 8->0 per byte; the byte count is unlimited.
REQ-028 SHALL give START/STOP detection priority over data sampling when both occur in the same clk.

Reset
REQ-029 SHALL, on rst low and regardless of clk: state=IDLE, sda released, data_out=8'h00, o_rxff_wr=0, o_txff_rd=0, busy=0, shift register and counter cleared, synchronizers preset to 1.
REQ-030 SHALL, on reset mid-transaction, release sda immediately and, after rst rises, ignore the bus until the next START.

Structure
REQ-031 SHALL place the state enum (i2c_slv_state_t) and the default address constant in package i2c_pkg, shared with i2c_master.
REQ-032 SHALL put the synchronizer and START/STOP/edge detection in one sub-module, i2c_line_sync, producing scl_rise, scl_fall, start_det, stop_det and sda_s.

Verification
REQ-033 Write 0x10+W, then 0x00,0x08,0x04,0x02 -> ACK on every byte; 4 o_rxff_wr pulses with data_out 00,08,04,02 in order.
REQ-034 Address 0x11+W -> sda never driven low, no o_rxff_wr, busy stays 0, IDLE after STOP.
REQ-035 Read 0x10+R, data_in=0xA5 then 0x3C, master ACK then NACK -> sda carries A5 then 3C; 2 o_txff_rd pulses; sda released after the NACK.
REQ-036 Write 0x10+W, 0x55, repeated START, 0x10+R, 1 byte with NACK -> one o_rxff_wr (0x55), then one o_txff_rd; busy high throughout until STOP.
REQ-037 STOP after 4 bits of a data byte -> no o_rxff_wr, IDLE, busy=0.
REQ-038 rst low while the slave drives ACK -> sda released in the same cycle; all outputs at reset values.
